alu_decode_stage: RTL and testbench

//   Registered decode stage that drives the ALU and its operand mux. Accepts one RV32

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_decode_comb.sv | 73 +++++++
 rtl/alu_decode_stage.sv | 68 ++++++
 tb/tb_alu_decode_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the ALU decode slice: ALU op codes, opcode constants and the decoded-field bundle.
package alu_pkg;

  typedef enum logic [3:0] {
    FOP_ADD = 4'd0,
    FOP_SUB = 4'd1,
    FOP_SLL = 4'd2,
    FOP_SRL = 4'd3,
    FOP_SRA = 4'd4,
    FOP_AND = 4'd5,
    FOP_OR  = 4'd6,
    FOP_XOR = 4'd7,
    FOP_IMM = 4'd8
  } fop_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef struct packed {
    fop_t        fop;
    logic        alu_mux_en;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
  } alu_dec_t;

endpackage

// File: rtl/alu_decode_comb.sv
// Pure combinational RV32 instruction decoder producing the ALU control bundle.
module alu_decode_comb
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output alu_dec_t    dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f3_ok;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // SLT/SLTU (010/011) have no ALU op here
  assign f3_ok  = (funct3 != 3'b010) && (funct3 != 3'b011);

  always_comb begin
    dec            = '0;
    dec.fop        = FOP_ADD;
    dec.rs1        = instr[19:15];
    dec.rs2        = instr[24:20];
    dec.rd         = instr[11:7];
    dec.illegal    = 1'b1;

    if (opcode == OPC_OP && f3_ok &&
        (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
      dec.illegal    = 1'b0;
      dec.alu_mux_en = 1'b1;
      case (funct3)
        3'b000:  dec.fop = funct7[5] ? FOP_SUB : FOP_ADD;
        3'b001:  dec.fop = FOP_SLL;
        3'b101:  dec.fop = funct7[5] ? FOP_SRA : FOP_SRL;
        3'b100:  dec.fop = FOP_XOR;
        3'b110:  dec.fop = FOP_OR;
        default: dec.fop = FOP_AND;
      endcase
    end else if (opcode == OPC_OP_IMM && f3_ok) begin
      dec.illegal = 1'b0;
      dec.rs2     = 5'd0;
      case (funct3)
        3'b001: begin
          dec.fop = FOP_SLL;
          dec.imm = {27'b0, instr[24:20]};
        end
        3'b101: begin
          dec.fop = instr[30] ? FOP_SRA : FOP_SRL;
          dec.imm = {27'b0, instr[24:20]};
        end
        default: begin
          case (funct3)
            3'b100:  dec.fop = FOP_XOR;
            3'b110:  dec.fop = FOP_OR;
            3'b111:  dec.fop = FOP_AND;
            default: dec.fop = FOP_ADD;
          endcase
          dec.imm = {{20{instr[31]}}, instr[31:20]};
        end
      endcase
    end else if (opcode == OPC_LUI) begin
      dec.illegal = 1'b0;
      dec.fop     = FOP_IMM;
      dec.imm     = {instr[31:12], 12'b0};
      dec.rs1     = 5'd0;
      dec.rs2     = 5'd0;
    end

    dec.reg_write = !dec.illegal && (dec.rd != 5'd0);
  end

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode stage with valid/ready handshake and flush between fetch and execute.
// Optional illegal-encoding output enabled by defining ALU_DEC_ILLEGAL_EN.
module alu_decode_stage
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        nRst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  fop,
  output logic        alu_mux_en,
  output logic [31:0] imm,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
`ifdef ALU_DEC_ILLEGAL_EN
  output logic        illegal,
`endif
  output logic        reg_write
);

  alu_dec_t dec_d;
  alu_dec_t dec_q;
  logic     capture;

  alu_decode_comb u_dec (
    .instr (instr),
    .dec   (dec_d)
  );

  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready;

  // Flush wins over capture; fields keep the last accepted word.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      out_valid <= 1'b0;
      dec_q     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      dec_q     <= dec_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign fop        = dec_q.fop;
  assign alu_mux_en = dec_q.alu_mux_en;
  assign imm        = dec_q.imm;
  assign rs1        = dec_q.rs1;
  assign rs2        = dec_q.rs2;
  assign rd         = dec_q.rd;
  assign reg_write  = dec_q.reg_write;

`ifdef ALU_DEC_ILLEGAL_EN
  assign illegal = out_valid && dec_q.illegal;
`else
  logic unused_illegal;
  assign unused_illegal = dec_q.illegal;
`endif

endmodule

// File: tb/tb_alu_decode_stage.sv
// Self-checking bench for alu_decode_stage: directed vectors, backpressure, flush, reset, random traffic.
module tb_alu_decode_stage;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  fop;
  logic        alu_mux_en;
  logic [31:0] imm;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_write;
`ifdef ALU_DEC_ILLEGAL_EN
  logic        illegal;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_decode_stage dut (
    .clk        (clk),
    .nRst       (nRst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fop        (fop),
    .alu_mux_en (alu_mux_en),
    .imm        (imm),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd         (rd),
`ifdef ALU_DEC_ILLEGAL_EN
    .illegal    (illegal),
`endif
    .reg_write  (reg_write)
  );

  typedef struct {
    logic [3:0]  fop;
    logic        mux;
    logic [31:0] imm;
    logic [4:0]  rs1, rs2, rd;
    logic        wr;
    logic        ill;
  } ref_t;

  ref_t m_q;
  logic m_valid;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference decode from the ISA rules, mnemonic by mnemonic.
  function automatic ref_t ref_dec(input logic [31:0] w);
    ref_t r;
    logic [6:0] op = w[6:0];
    logic [2:0] f3 = w[14:12];
    logic [6:0] f7 = w[31:25];
    logic       alt = (f7 == 7'h20);
    r.fop = 4'd0; r.mux = 1'b0; r.imm = 32'd0;
    r.rs1 = w[19:15]; r.rs2 = w[24:20]; r.rd = w[11:7];
    r.ill = 1'b1;
    if (op == 7'h33 && (f7 == 7'h00 || f7 == 7'h20) && f3 != 3'd2 && f3 != 3'd3) begin
      r.ill = 1'b0;
      r.mux = 1'b1;
      if (f3 == 3'd0)      r.fop = alt ? 4'd1 : 4'd0;
      else if (f3 == 3'd1) r.fop = 4'd2;
      else if (f3 == 3'd5) r.fop = alt ? 4'd4 : 4'd3;
      else if (f3 == 3'd4) r.fop = 4'd7;
      else if (f3 == 3'd6) r.fop = 4'd6;
      else                 r.fop = 4'd5;
    end else if (op == 7'h13 && f3 != 3'd2 && f3 != 3'd3) begin
      r.ill = 1'b0;
      r.rs2 = 5'd0;
      if (f3 == 3'd1 || f3 == 3'd5) begin
        r.imm = 32'(w[24:20]);
        r.fop = (f3 == 3'd1) ? 4'd2 : (w[30] ? 4'd4 : 4'd3);
      end else begin
        r.imm = 32'($signed(w[31:20]));
        if (f3 == 3'd0)      r.fop = 4'd0;
        else if (f3 == 3'd4) r.fop = 4'd7;
        else if (f3 == 3'd6) r.fop = 4'd6;
        else                 r.fop = 4'd5;
      end
    end else if (op == 7'h37) begin
      r.ill = 1'b0;
      r.fop = 4'd8;
      r.imm = w & 32'hFFFF_F000;
      r.rs1 = 5'd0;
      r.rs2 = 5'd0;
    end
    r.wr = !r.ill && (r.rd != 5'd0);
    return r;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 5))
      0: begin w[6:0] = 7'h33; w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
      1: w[6:0] = 7'h13;
      2: w[6:0] = 7'h37;
      3: ;
      4: w[6:0] = 7'h33;
      default: begin w[6:0] = 7'h13; w[14:12] = $urandom_range(0, 1) ? 3'd1 : 3'd5; end
    endcase
    return w;
  endfunction

  task automatic compare_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
`ifdef ALU_DEC_ILLEGAL_EN
    chk({tag, ".illegal"}, 32'(illegal), 32'(m_valid && m_q.ill));
`endif
    if (m_valid) begin
      chk({tag, ".fop"}, 32'(fop), 32'(m_q.fop));
      chk({tag, ".mux"}, 32'(alu_mux_en), 32'(m_q.mux));
      chk({tag, ".imm"}, imm, m_q.imm);
      chk({tag, ".reg_write"}, 32'(reg_write), 32'(m_q.wr));
      if (!m_q.ill) begin
        chk({tag, ".rs1"}, 32'(rs1), 32'(m_q.rs1));
        chk({tag, ".rs2"}, 32'(rs2), 32'(m_q.rs2));
        chk({tag, ".rd"}, 32'(rd), 32'(m_q.rd));
      end
    end
  endtask

  // Called at a negedge: drive, check in_ready, take one edge, check outputs at next negedge.
  task automatic step(input string tag, input logic v, input logic [31:0] w,
                      input logic ordy, input logic fl);
    logic cap;
    in_valid = v; instr = w; out_ready = ordy; flush = fl;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid || ordy));
    cap = v && (!m_valid || ordy);
    @(posedge clk);
    if (fl)        m_valid = 1'b0;
    else if (cap) begin m_valid = 1'b1; m_q = ref_dec(w); end
    else if (ordy) m_valid = 1'b0;
    @(negedge clk);
    compare_outputs(tag);
  endtask

  initial begin
    m_valid = 1'b0;
    m_q = ref_dec(32'd0);
    m_q.ill = 1'b0; m_q.rs1 = 0; m_q.rs2 = 0; m_q.rd = 0; m_q.wr = 0;
    repeat (2) @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.fop", 32'(fop), 0);
    chk("rst.imm", imm, 0);
    chk("rst.rd", 32'(rd), 0);
    nRst = 1'b1;
    @(negedge clk);
    chk("rst.in_ready", 32'(in_ready), 1);

    step("add", 1, 32'h002081B3, 1, 0);
    chk("add.fop_k", 32'(fop), 0);
    chk("add.mux_k", 32'(alu_mux_en), 1);
    chk("add.regs_k", {17'd0, rs1, rs2, rd}, {17'd0, 5'd1, 5'd2, 5'd3});
    chk("add.wr_k", 32'(reg_write), 1);
    step("sub", 1, 32'h407302B3, 1, 0);
    chk("sub.fop_k", 32'(fop), 1);
    step("srai", 1, 32'h4030D093, 1, 0);
    chk("srai.fop_k", 32'(fop), 4);
    chk("srai.imm_k", imm, 32'h3);
    step("lui", 1, 32'h12345537, 1, 0);
    chk("lui.fop_k", 32'(fop), 8);
    chk("lui.imm_k", imm, 32'h12345000);
    step("addi", 1, 32'hFFF00093, 1, 0);
    chk("addi.imm_k", imm, 32'hFFFFFFFF);
    step("slt", 1, 32'h0020A1B3, 1, 0);
    chk("slt.wr_k", 32'(reg_write), 0);
    chk("slt.fop_k", 32'(fop), 0);
`ifdef ALU_DEC_ILLEGAL_EN
    chk("slt.illegal_k", 32'(illegal), 1);
`endif
    step("drain", 0, 32'h0, 1, 0);

    // Backpressure: hold A for three cycles while B waits
    step("bp_a", 1, 32'h002081B3, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step("bp_hold", 1, 32'h407302B3, 0, 0);
      chk("bp.in_ready_k", 32'(in_ready), 0);
      chk("bp.fop_hold_k", 32'(fop), 0);
    end
    step("bp_rel", 1, 32'h407302B3, 1, 0);
    chk("bp.next_fop_k", 32'(fop), 1);

    // Flush with a simultaneous capture drops the word
    step("fl_a", 1, 32'h12345537, 1, 0);
    step("fl_cap", 1, 32'h002081B3, 1, 1);
    chk("flush.out_valid_k", 32'(out_valid), 0);

    step("rst_pre", 1, 32'hFFF00093, 1, 0);
    in_valid = 1'b0;
    nRst = 1'b0;
    #1;
    chk("rst_mid.out_valid", 32'(out_valid), 0);
    chk("rst_mid.imm", imm, 0);
    chk("rst_mid.fields", {19'd0, fop, alu_mux_en, rs1, rd, reg_write}, 0);
    m_valid = 1'b0;
    #2 nRst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 3) != 0), gen_instr(),
           ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
